// File: rtl/flash_arbiter_pkg.sv
// Shared types and the round-robin pick used by flash_arbiter.
// Requester vectors are handled at MaxReq width so the pick logic is parameter-independent.
package flash_arbiter_pkg;

    localparam int unsigned MaxReq  = 4;
    localparam int unsigned IdxBits = 2;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitReady,
        StDone
    } t_arb_state;

    // First requesting index strictly after last_idx, wrapping within num_req.
    function automatic logic [IdxBits-1:0] rr_next(input logic [MaxReq-1:0]  req,
                                                   input logic [IdxBits-1:0] last_idx,
                                                   input int unsigned        num_req);
        logic [IdxBits-1:0] pick;
        int unsigned        cand;
        pick = last_idx;
        // Walk from the farthest offset down so the nearest requester is assigned last.
        for (int unsigned off = MaxReq; off > 0; off--) begin
            cand = (int'(last_idx) + off) % num_req;
            if (off <= num_req && req[cand]) begin
                pick = IdxBits'(cand);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/flash_arbiter.sv
// Round-robin arbiter that shares one flash_serial controller between NUM_REQ requesters,
// sequencing the enable/write/erase handshake with a watchdog abort.
module flash_arbiter
    import flash_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned WORD_BITS     = 8,
    parameter int unsigned ADDRESS_WORDS = 3,
    parameter int unsigned TIMEOUT       = 27_000_000
) (
    input  logic                                    in_clk,
    input  logic                                    in_rst,
    input  logic [NUM_REQ-1:0]                      in_req,
    input  logic [NUM_REQ-1:0]                      in_write,
    input  logic [NUM_REQ-1:0]                      in_erase,
    input  logic [NUM_REQ*WORD_BITS*ADDRESS_WORDS-1:0] in_addr,
    input  logic [NUM_REQ*WORD_BITS-1:0]            in_data,
    output logic [NUM_REQ-1:0]                      out_grant,
    output logic [NUM_REQ-1:0]                      out_done,
    output logic [NUM_REQ-1:0]                      out_error,
    output logic [WORD_BITS-1:0]                    out_data,
    output logic                                    out_busy,
    output logic                                    out_flash_enable,
    output logic                                    out_flash_write,
    output logic                                    out_flash_erase,
    output logic [WORD_BITS*ADDRESS_WORDS-1:0]      out_flash_addr,
    output logic [WORD_BITS-1:0]                    out_flash_data,
    input  logic [WORD_BITS-1:0]                    in_flash_data,
    input  logic                                    in_flash_word_finished,
    input  logic                                    in_flash_next_word,
    input  logic                                    in_flash_ready
);

    localparam int unsigned AddrBits = WORD_BITS * ADDRESS_WORDS;
    localparam int unsigned WdogBits = $clog2(TIMEOUT + 1);
    localparam logic [NUM_REQ-1:0] OneHotBase = NUM_REQ'(1);

    t_arb_state state, state_next;

    logic [IdxBits-1:0]   cmd_idx;
    logic                 cmd_write;
    logic                 cmd_erase;
    logic [AddrBits-1:0]  cmd_addr;
    logic [WORD_BITS-1:0] cmd_data;
    logic [IdxBits-1:0]   last_idx;
    logic [WdogBits-1:0]  wdog;
    logic [WORD_BITS-1:0] read_data;
    logic                 next_word_prev;
    logic                 word_finished_prev;

    logic [MaxReq-1:0]           req_ext;
    logic [MaxReq-1:0]           write_ext;
    logic [MaxReq-1:0]           erase_ext;
    logic [MaxReq*AddrBits-1:0]  addr_ext;
    logic [MaxReq*WORD_BITS-1:0] data_ext;
    logic [IdxBits-1:0]          pick;

    logic next_word_rise;
    logic word_finished_fall;
    logic issue_edge;
    logic wdog_expired;
    logic grant_load;
    logic load_read;
    logic done_pulse;
    logic error_pulse;
    logic enable;

    assign req_ext   = MaxReq'(in_req);
    assign write_ext = MaxReq'(in_write);
    assign erase_ext = MaxReq'(in_erase);
    assign addr_ext  = (MaxReq * AddrBits)'(in_addr);
    assign data_ext  = (MaxReq * WORD_BITS)'(in_data);
    assign pick      = rr_next(req_ext, last_idx, NUM_REQ);

    assign next_word_rise     = in_flash_next_word & ~next_word_prev;
    assign word_finished_fall = ~in_flash_word_finished & word_finished_prev;
    assign issue_edge         = cmd_write ? next_word_rise : word_finished_fall;
    assign wdog_expired       = (wdog == WdogBits'(TIMEOUT));

    always_comb begin
        state_next  = state;
        grant_load  = 1'b0;
        load_read   = 1'b0;
        done_pulse  = 1'b0;
        error_pulse = 1'b0;
        enable      = 1'b0;
        unique case (state)
            StIdle: begin
                if (in_flash_ready && (|in_req)) begin
                    grant_load = 1'b1;
                    state_next = StIssue;
                end
            end
            StIssue: begin
                if (wdog_expired) begin
                    error_pulse = 1'b1;
                    state_next  = StIdle;
                end else if (issue_edge) begin
                    // Enable drops combinationally in the cycle the qualifying edge appears.
                    load_read  = ~cmd_write;
                    state_next = StWaitReady;
                end else begin
                    enable = 1'b1;
                end
            end
            StWaitReady: begin
                if (wdog_expired) begin
                    error_pulse = 1'b1;
                    state_next  = StIdle;
                end else if (in_flash_ready) begin
                    state_next = StDone;
                end
            end
            StDone: begin
                done_pulse = 1'b1;
                state_next = StIdle;
            end
            default: state_next = StIdle;
        endcase
    end

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state              <= StIdle;
            cmd_idx            <= '0;
            cmd_write          <= 1'b0;
            cmd_erase          <= 1'b0;
            cmd_addr           <= '0;
            cmd_data           <= '0;
            last_idx           <= IdxBits'(NUM_REQ - 1);
            wdog               <= '0;
            read_data          <= '0;
            next_word_prev     <= 1'b0;
            word_finished_prev <= 1'b0;
        end else begin
            state              <= state_next;
            next_word_prev     <= in_flash_next_word;
            word_finished_prev <= in_flash_word_finished;
            if (grant_load) begin
                cmd_idx   <= pick;
                cmd_write <= write_ext[pick] | erase_ext[pick];
                cmd_erase <= erase_ext[pick];
                cmd_addr  <= addr_ext[int'(pick)*AddrBits +: AddrBits];
                cmd_data  <= data_ext[int'(pick)*WORD_BITS +: WORD_BITS];
            end
            if (load_read) begin
                read_data <= in_flash_data;
            end
            if (grant_load) begin
                wdog <= '0;
            end else if (state == StIssue || state == StWaitReady) begin
                wdog <= wdog + WdogBits'(1);
            end
            if (done_pulse || error_pulse) begin
                last_idx <= cmd_idx;
            end
        end
    end

    assign out_busy         = (state != StIdle);
    assign out_grant        = out_busy ? (OneHotBase << cmd_idx) : '0;
    assign out_done         = done_pulse ? (OneHotBase << cmd_idx) : '0;
    assign out_error        = error_pulse ? (OneHotBase << cmd_idx) : '0;
    assign out_data         = read_data;
    assign out_flash_enable = enable;
    assign out_flash_write  = cmd_write;
    assign out_flash_erase  = cmd_erase;
    assign out_flash_addr   = cmd_addr;
    assign out_flash_data   = cmd_data;

endmodule

// File: tb/tb_flash_arbiter.sv
// Scoreboard bench for flash_arbiter: randomized requester rounds, a behavioural flash model,
// and a monitor that checks every done/error pulse against the expected service order.
module tb_flash_arbiter;

    localparam int unsigned NR = 3;
    localparam int unsigned WB = 8;
    localparam int unsigned AW = 3;
    localparam int unsigned AB = WB * AW;
    localparam int unsigned TO = 50;

    localparam int FmIdle    = 0;
    localparam int FmDelay   = 1;
    localparam int FmRecover = 2;
    localparam int FmStall   = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] in_req = '0;
    logic [NR-1:0] in_write = '0;
    logic [NR-1:0] in_erase = '0;
    logic [NR*AB-1:0] in_addr = '0;
    logic [NR*WB-1:0] in_data = '0;
    logic [NR-1:0] out_grant, out_done, out_error;
    logic [WB-1:0] out_data;
    logic          out_busy, out_flash_enable, out_flash_write, out_flash_erase;
    logic [AB-1:0] out_flash_addr;
    logic [WB-1:0] out_flash_data;
    logic [WB-1:0] fl_data = '0;
    logic          fl_wf = 1'b0, fl_nw = 1'b0, fl_ready = 1'b1;

    always #5 clk = ~clk;

    flash_arbiter #(.NUM_REQ(NR), .WORD_BITS(WB), .ADDRESS_WORDS(AW), .TIMEOUT(TO)) dut (
        .in_clk(clk), .in_rst(rst),
        .in_req(in_req), .in_write(in_write), .in_erase(in_erase),
        .in_addr(in_addr), .in_data(in_data),
        .out_grant(out_grant), .out_done(out_done), .out_error(out_error),
        .out_data(out_data), .out_busy(out_busy),
        .out_flash_enable(out_flash_enable), .out_flash_write(out_flash_write),
        .out_flash_erase(out_flash_erase), .out_flash_addr(out_flash_addr),
        .out_flash_data(out_flash_data), .in_flash_data(fl_data),
        .in_flash_word_finished(fl_wf), .in_flash_next_word(fl_nw), .in_flash_ready(fl_ready)
    );

    typedef struct {
        int          idx;
        bit          wr;
        bit          er;
        logic [23:0] addr;
        logic [7:0]  data;
        bit          err;
    } exp_t;

    exp_t   exp_q[$];
    int     vectors = 0;
    int     miscompares = 0;
    longint cyc = 0;
    bit     rst_at_edge = 1'b1;
    int     kill_cnt = 0;
    int     fm_st = FmIdle;
    bit     seen_wr, seen_er;
    logic [AB-1:0] seen_addr;
    logic [WB-1:0] seen_wdata;
    longint seen_cyc;
    int     last_win = NR - 1;
    bit     r_wr[NR], r_er[NR];
    logic [AB-1:0] r_addr[NR];
    logic [WB-1:0] r_data[NR];

    always @(posedge clk) begin
        cyc         <= cyc + 1;
        rst_at_edge <= rst;
    end

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [WB-1:0] mem_word(input logic [AB-1:0] a);
        return a[7:0] + 8'h13;
    endfunction

    // Flash model: write completes on a next_word pulse, read on a word_finished fall.
    // Address bit 23 stalls forever; bit 22 stretches the not-ready recovery.
    initial begin
        int delay, rec, kill_seen;
        kill_seen = 0;
        forever begin
            @(negedge clk);
            if (kill_cnt != kill_seen) begin
                kill_seen = kill_cnt;
                fm_st = FmIdle; fl_ready = 1'b1; fl_nw = 1'b0; fl_wf = 1'b0;
            end else begin
                case (fm_st)
                    FmIdle: if (out_flash_enable) begin
                        seen_wr = out_flash_write; seen_er = out_flash_erase;
                        seen_addr = out_flash_addr; seen_wdata = out_flash_data;
                        seen_cyc = cyc; fl_ready = 1'b0;
                        if (seen_addr[23]) fm_st = FmStall;
                        else begin
                            delay = $urandom_range(1, 4);
                            rec = seen_addr[22] ? 10 : $urandom_range(0, 3);
                            if (!seen_wr) begin
                                fl_wf = 1'b1;
                                fl_data = mem_word(seen_addr);
                            end
                            fm_st = FmDelay;
                        end
                    end
                    FmDelay: begin
                        check("enable_held", 64'(out_flash_enable), 64'd1);
                        delay--;
                        if (delay == 0) begin
                            if (seen_wr) fl_nw = 1'b1;
                            else fl_wf = 1'b0;
                            #1;
                            check("enable_drop_on_edge", 64'(out_flash_enable), 64'd0);
                            fm_st = FmRecover;
                        end
                    end
                    FmRecover: begin
                        fl_nw = 1'b0;
                        if (rec == 0) begin
                            fl_ready = 1'b1;
                            fm_st = FmIdle;
                        end else rec--;
                    end
                    default: if (!out_flash_enable) begin
                        fl_ready = 1'b1;
                        fm_st = FmIdle;
                    end
                endcase
            end
        end
    end

    // Monitor: pops one expectation per done/error pulse.
    initial begin
        exp_t          e;
        logic [NR-1:0] oh;
        logic [WB-1:0] model_rdata;
        bit            chk_idle;
        model_rdata = '0;
        chk_idle = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_at_edge) model_rdata = '0;
            if (chk_idle) begin
                check("idle_after_end_busy", 64'(out_busy), 64'd0);
                check("idle_after_end_grant", 64'(out_grant), 64'd0);
                chk_idle = 1'b0;
            end
            if ((|out_done) || (|out_error)) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 64'(out_done | out_error), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    oh = NR'(1) << e.idx;
                    check("done_pulse", 64'(out_done), e.err ? 64'd0 : 64'(oh));
                    check("error_pulse", 64'(out_error), e.err ? 64'(oh) : 64'd0);
                    check("grant", 64'(out_grant), 64'(oh));
                    check("busy", 64'(out_busy), 64'd1);
                    check("flash_write", 64'(seen_wr), 64'(e.wr | e.er));
                    check("flash_erase", 64'(seen_er), 64'(e.er));
                    check("flash_addr", 64'(seen_addr), 64'(e.addr));
                    check("flash_wdata", 64'(seen_wdata), 64'(e.data));
                    if (e.err) check("timeout_latency", 64'(cyc - seen_cyc), 64'(TO));
                    else if (!e.wr && !e.er) model_rdata = mem_word(e.addr);
                    check("read_data", 64'(out_data), 64'(model_rdata));
                    chk_idle = 1'b1;
                end
            end
        end
    end

    task automatic drive_ops();
        for (int i = 0; i < NR; i++) begin
            in_write[i] = r_wr[i];
            in_erase[i] = r_er[i];
            in_addr[i*AB +: AB] = r_addr[i];
            in_data[i*WB +: WB] = r_data[i];
        end
    endtask

    // All requesters in mask assert together and drop once served; the expected service
    // order is the round-robin walk over the pending set.
    task automatic run_round(input logic [NR-1:0] mask, output bit ok);
        logic [NR-1:0] left;
        int cur, t, c;
        left = mask;
        cur = last_win;
        while (left != 0) begin
            for (int k = 1; k <= NR; k++) begin
                c = (cur + k) % NR;
                if (left[c]) begin
                    cur = c;
                    break;
                end
            end
            exp_q.push_back('{cur, r_wr[cur], r_er[cur], r_addr[cur], r_data[cur],
                              r_addr[cur][23]});
            left[cur] = 1'b0;
        end
        last_win = cur;
        drive_ops();
        in_req = mask;
        t = 0;
        while (in_req != 0 && t < 800) begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) if (out_done[i] || out_error[i]) in_req[i] = 1'b0;
            t++;
        end
        ok = (in_req == 0);
        if (!ok) check("round_timeout", 64'(in_req), 64'd0);
        in_req = '0;
        @(negedge clk);
    endtask

    task automatic run_held(input int n, output bit ok);
        int got, t, cur;
        cur = last_win;
        for (int k = 0; k < n; k++) begin
            cur = (cur + 1) % NR;
            exp_q.push_back('{cur, r_wr[cur], r_er[cur], r_addr[cur], r_data[cur], 1'b0});
        end
        last_win = cur;
        drive_ops();
        in_req = '1;
        got = 0;
        t = 0;
        while (got < n && t < 2000) begin
            @(negedge clk);
            if ((|out_done) || (|out_error)) got++;
            t++;
        end
        in_req = '0;
        ok = (got == n);
        if (!ok) check("held_timeout", 64'(got), 64'(n));
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 64'(out_grant), 64'd0);
        check({tag, "_done"}, 64'(out_done), 64'd0);
        check({tag, "_error"}, 64'(out_error), 64'd0);
        check({tag, "_data"}, 64'(out_data), 64'd0);
        check({tag, "_busy"}, 64'(out_busy), 64'd0);
        check({tag, "_enable"}, 64'(out_flash_enable), 64'd0);
        check({tag, "_fwrite"}, 64'(out_flash_write), 64'd0);
        check({tag, "_ferase"}, 64'(out_flash_erase), 64'd0);
        check({tag, "_faddr"}, 64'(out_flash_addr), 64'd0);
        check({tag, "_fdata"}, 64'(out_flash_data), 64'd0);
    endtask

    task automatic set_op(input int i, input bit wr, input bit er, input logic [AB-1:0] a,
                          input logic [WB-1:0] d);
        r_wr[i] = wr; r_er[i] = er; r_addr[i] = a; r_data[i] = d;
    endtask

    initial begin
        bit ok;
        int t;
        ok = 1'b1;
        for (int i = 0; i < NR; i++) set_op(i, 1'b0, 1'b0, '0, '0);
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Simultaneous writes right after reset: requester 0 first, then 1.
        set_op(0, 1'b1, 1'b0, 24'h000100, 8'hA1);
        set_op(1, 1'b1, 1'b0, 24'h000200, 8'hB2);
        run_round(3'b011, ok);
        // Read returning mem_word(0x10) = 0x23.
        if (ok) begin
            set_op(0, 1'b0, 1'b0, 24'h000010, 8'h00);
            run_round(3'b001, ok);
        end
        if (ok) begin
            set_op(1, 1'b0, 1'b1, 24'h012000, 8'h5C);
            run_round(3'b010, ok);
        end
        // Flash never answers: watchdog abort.
        if (ok) begin
            set_op(0, 1'b0, 1'b0, 24'h800040, 8'h11);
            run_round(3'b001, ok);
        end

        // Reset while the read waits for ready; nothing completes and arbitration restarts.
        if (ok) begin
            set_op(0, 1'b0, 1'b0, 24'h400020, 8'h00);
            drive_ops();
            in_req = 3'b001;
            t = 0;
            while (fm_st != FmRecover && t < 100) begin
                @(negedge clk);
                t++;
            end
            check("reach_wait_ready", 64'(fm_st), 64'(FmRecover));
            repeat (2) @(negedge clk);
            rst = 1'b1;
            in_req = '0;
            kill_cnt++;
            @(negedge clk);
            check_all_zero("mid_reset");
            rst = 1'b0;
            last_win = NR - 1;
            @(negedge clk);
            check("no_done_after_reset", 64'(out_done), 64'd0);
            for (int i = 0; i < NR; i++)
                set_op(i, 1'($urandom_range(0, 1)), 1'b0, AB'($urandom_range(0, 24'h3FFFFF)),
                       WB'($urandom));
            run_held(6, ok);
        end

        for (int r = 0; r < 40 && ok; r++) begin
            for (int i = 0; i < NR; i++) begin
                logic [AB-1:0] a;
                a = AB'($urandom) & 24'h3FFFFF;
                if ($urandom_range(0, 9) == 0) a[23] = 1'b1;
                set_op(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0), a,
                       WB'($urandom));
            end
            run_round(NR'($urandom_range(1, (1 << NR) - 1)), ok);
        end

        repeat (5) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
